// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_pkg;

  // Fetch group width; the aligner is built for exactly this many slots.
  localparam int FETCH_SLOTS = 4;

  // Width of a consumed-instruction count (0..FETCH_SLOTS).
  localparam int COUNT_W = 3;

  // First PC fetched after reset unless overridden at the top.
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    ST_BOOT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_MISS  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_leading_ones4.sv
// Counts the leading run of ones in a 4-bit slot-valid mask, from bit3 down.
// Latency: purely combinational.
// Backpressure: none.
// Ports: valid (slot mask, bit3 = first slot), count (0..4).
module leading_ones4
  import fetch_pkg::*;
(
  input  logic [3:0]         valid,
  output logic [COUNT_W-1:0] count
);

  // Only the contiguous run starting at the first slot counts; any hole
  // ends the group, so 4'b1011 is one instruction and 4'b0111 is none.
  always_comb begin
    count = '0;
    if (valid == 4'b1111)
      count = COUNT_W'(4);
    else if (valid[3:1] == 3'b111)
      count = COUNT_W'(3);
    else if (valid[3:2] == 2'b11)
      count = COUNT_W'(2);
    else if (valid[3])
      count = COUNT_W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the fetch PC; issues fetch requests and advances by instructions consumed.
// Latency: o_Pc updates one cycle after the accepting/redirecting cycle.
// Backpressure: holds PC on i_Stall or I-cache miss; redirect overrides all.
//
// Ports:
//   i_Clk, i_Reset          clock, asynchronous active-high reset
//   i_Stall                 downstream queues cannot take a group this cycle
//   i_Icache_ready          I-cache hit for o_Pc this cycle
//   i_Valid[3:0]            aligner slot-valid mask, bit3 = first slot
//   i_Redirect, i_Redirect_pc  one-cycle redirect pulse and target
//   o_Pc, o_Fetch_req       current fetch PC and request valid
//   o_Accept, o_Count       group accepted this cycle and its size (0..4)
// Optional build macro FETCH_PERF_CNT_EN adds o_Insn_cnt, o_Stall_cnt,
// o_Miss_cnt (32-bit saturating, cleared on reset).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
  parameter int                       SLOTS         = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset,
  input  logic                     i_Stall,
  input  logic                     i_Icache_ready,
  input  logic [3:0]               i_Valid,
  input  logic                     i_Redirect,
  input  logic [ADDRESS_WIDTH-1:0] i_Redirect_pc,
  output logic [ADDRESS_WIDTH-1:0] o_Pc,
  output logic                     o_Fetch_req,
  output logic                     o_Accept,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]              o_Insn_cnt,
  output logic [31:0]              o_Stall_cnt,
  output logic [31:0]              o_Miss_cnt,
`endif
  output logic [COUNT_W-1:0]       o_Count
);

  generate
    if (SLOTS != FETCH_SLOTS) begin : g_bad_slots
      $error("fetch_sequencer: SLOTS must be 4");
    end
  endgenerate

  fetch_state_t             state, state_next;
  logic [ADDRESS_WIDTH-1:0] pc_next;
  logic [COUNT_W-1:0]       lead_count;
  logic [COUNT_W-1:0]       advance;
  logic                     error_flag;
  logic                     error_set;
  logic                     accept;

  leading_ones4 u_lead (
    .valid (i_Valid),
    .count (lead_count)
  );

  // A zero-length group still moves the PC by one so a bad mask cannot
  // wedge the front end; the event is remembered in error_flag.
  assign advance = (lead_count == '0) ? COUNT_W'(1) : lead_count;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state      <= ST_BOOT;
      o_Pc       <= RESET_PC;
      error_flag <= 1'b0;
    end else begin
      state      <= state_next;
      o_Pc       <= pc_next;
      error_flag <= error_flag | error_set;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = o_Pc;
    o_Fetch_req = 1'b0;
    accept      = 1'b0;
    error_set   = 1'b0;

    case (state)
      ST_BOOT: begin
        // A redirect arriving during boot is captured but boot still
        // completes its single idle cycle.
        state_next = ST_FETCH;
        if (i_Redirect)
          pc_next = i_Redirect_pc;
      end

      ST_FETCH, ST_MISS, ST_HOLD: begin
        o_Fetch_req = 1'b1;
        // HOLD waits on the stall first; FETCH and MISS look at the
        // cache first. Either way an unblocked cycle behaves as FETCH.
        if (state == ST_HOLD && i_Stall)
          state_next = ST_HOLD;
        else if (!i_Icache_ready)
          state_next = ST_MISS;
        else if (i_Stall)
          state_next = ST_HOLD;
        else begin
          state_next = ST_FETCH;
          accept     = 1'b1;
          pc_next    = o_Pc + {{(ADDRESS_WIDTH-COUNT_W){1'b0}}, advance};
          error_set  = (lead_count == '0);
        end
      end

      ST_FLUSH: begin
        state_next = ST_FETCH;
      end

      default: begin
        state_next = ST_BOOT;
      end
    endcase

    // Redirect wins over any group or stall outside of boot; a redirect
    // during FLUSH simply restarts the bubble at the newer target.
    if (i_Redirect && state != ST_BOOT) begin
      state_next = ST_FLUSH;
      pc_next    = i_Redirect_pc;
      accept     = 1'b0;
      error_set  = 1'b0;
    end
  end

  assign o_Accept = accept;
  assign o_Count  = accept ? lead_count : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] insn_sum;
  assign insn_sum = {1'b0, o_Insn_cnt} + {{(33-COUNT_W){1'b0}}, o_Count};

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      o_Insn_cnt  <= '0;
      o_Stall_cnt <= '0;
      o_Miss_cnt  <= '0;
    end else begin
      o_Insn_cnt <= insn_sum[32] ? 32'hFFFF_FFFF : insn_sum[31:0];
      if (state == ST_HOLD && o_Stall_cnt != 32'hFFFF_FFFF)
        o_Stall_cnt <= o_Stall_cnt + 32'd1;
      if (state == ST_MISS && o_Miss_cnt != 32'hFFFF_FFFF)
        o_Miss_cnt <= o_Miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios then random
// traffic, all compared against a behavioural PC/bubble model.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ready;
  logic [3:0]  valid;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] pc;
  logic        fetch_req;
  logic        accept;
  logic [2:0]  count;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] insn_cnt, stall_cnt, miss_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: PC, whether the boot cycle or a post-redirect bubble
  // is pending, and the sticky bad-mask flag.
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_bubble;
  bit          m_err;

  fetch_sequencer #(
    .ADDRESS_WIDTH (32),
    .RESET_PC      (32'h0000_0000),
    .SLOTS         (4)
  ) dut (
    .i_Clk          (clk),
    .i_Reset        (rst),
    .i_Stall        (stall),
    .i_Icache_ready (ready),
    .i_Valid        (valid),
    .i_Redirect     (redir),
    .i_Redirect_pc  (redir_pc),
    .o_Pc           (pc),
    .o_Fetch_req    (fetch_req),
    .o_Accept       (accept),
`ifdef FETCH_PERF_CNT_EN
    .o_Insn_cnt     (insn_cnt),
    .o_Stall_cnt    (stall_cnt),
    .o_Miss_cnt     (miss_cnt),
`endif
    .o_Count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lead_ones(input logic [3:0] v);
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) break;
      n++;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = 32'h0;
    m_boot   = 1'b1;
    m_bubble = 1'b0;
    m_err    = 1'b0;
  endtask

  // One clock: check combinational outputs against the model with the
  // inputs already applied, then advance the model on the edge.
  task automatic cycle();
    bit exp_req, exp_acc;
    int n;
    #1;
    n       = lead_ones(valid);
    exp_req = !m_boot && !m_bubble;
    exp_acc = exp_req && !redir && ready && !stall;
    chk("pc",        pc,                 m_pc);
    chk("fetch_req", 32'(fetch_req),     32'(exp_req));
    chk("accept",    32'(accept),        32'(exp_acc));
    chk("count",     32'(count),         exp_acc ? 32'(n) : 32'd0);
    chk("err_flag",  32'(dut.error_flag), 32'(m_err));
    @(posedge clk);
    if (m_boot) begin
      if (redir) m_pc = redir_pc;
      m_boot = 1'b0;
    end else if (redir) begin
      m_pc     = redir_pc;
      m_bubble = 1'b1;
    end else if (m_bubble) begin
      m_bubble = 1'b0;
    end else if (exp_acc) begin
      m_pc = m_pc + ((n == 0) ? 32'd1 : 32'(n));
      if (n == 0) m_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic reset_checks();
    #1;
    chk("rst_pc",        pc,             32'h0);
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_accept",    32'(accept),    32'd0);
    chk("rst_count",     32'(count),     32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redir    = 1'b1;
    redir_pc = target;
    cycle();
    redir    = 1'b0;
    cycle();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ready = 1'b1; valid = 4'hF;
    redir = 1'b0; redir_pc = 32'h0;
    model_reset();
    @(negedge clk);
    reset_checks();
    @(negedge clk);
    rst = 1'b0;

    // Boot bubble then sequential full groups.
    cycle();
    for (int k = 0; k < 4; k++) begin
      chk("seq_pc", pc, 32'(k * 4));
      cycle();
    end

    // Unaligned start and partial groups.
    redirect_to(32'd5);
    valid = 4'b1110;
    cycle();
    chk("pc_after_3", pc, 32'd8);
    valid = 4'b1100;
    cycle();
    chk("pc_after_2", pc, 32'd10);
    valid = 4'b1011;
    cycle();
    chk("pc_noncontig", pc, 32'd11);

    // I-cache miss for three cycles.
    redirect_to(32'd16);
    ready = 1'b0;
    valid = 4'b1111;
    repeat (3) begin
      chk("miss_pc", pc, 32'd16);
      cycle();
    end
    ready = 1'b1;
    cycle();
    chk("miss_done_pc", pc, 32'd20);

    // Stall, then redirect while still stalled.
    stall = 1'b1;
    repeat (2) cycle();
    redir = 1'b1; redir_pc = 32'h100;
    cycle();
    redir = 1'b0; stall = 1'b0;
    chk("flush_pc", pc, 32'h100);
    cycle();
    chk("resume_pc", pc, 32'h100);
    cycle();

    // Wraparound and the zero-count escape.
    redirect_to(32'hFFFF_FFFE);
    valid = 4'b1111;
    cycle();
    chk("wrap_pc", pc, 32'h2);
    valid = 4'b0111;
    cycle();
    chk("zero_adv_pc", pc, 32'h3);
    chk("err_set", 32'(dut.error_flag), 32'd1);

    // Back-to-back redirects: the later target wins.
    redir = 1'b1; redir_pc = 32'h40;
    cycle();
    redir_pc = 32'h80;
    cycle();
    redir = 1'b0;
    cycle();
    chk("b2b_pc", pc, 32'h80);

    // Asynchronous reset in the middle of a stall, between clock edges.
    valid = 4'hF;
    stall = 1'b1;
    repeat (2) cycle();
    #2;
    rst = 1'b1;
    reset_checks();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    cycle();
    chk("post_rst_pc", pc, 32'h0);

    // Random traffic including redirects near the wrap point.
    for (int i = 0; i < 600; i++) begin
      stall    = ($urandom_range(0, 3) == 0);
      ready    = ($urandom_range(0, 4) != 0);
      valid    = ($urandom_range(0, 1) == 0) ? 4'(4'hF << $urandom_range(0, 4))
                                             : 4'($urandom_range(0, 15));
      redir    = ($urandom_range(0, 15) == 0);
      redir_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                             : $urandom;
      cycle();
    end
    redir = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a hang anywhere in the sequence.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
